spi_master: RTL and testbench

//  SPI initiator for the 16-bit {data,address} frame used by the board SPI slave. Drives ss, sclk, mosi; samples miso.

---
 rtl/spi_master_pkg.sv | 26 ++
 rtl/spi_master_timer.sv | 38 +++
 rtl/spi_master.sv | 213 +++++++++++++++++++++
 tb/tb_spi_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared frame widths, FSM state encoding and a small sizing helper for the SPI initiator.
package spi_master_pkg;

    localparam int SPI_FRAME_W = 16;
    localparam int SPI_DATA_W  = 8;
    localparam int SPI_ADDR_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    function automatic int spi_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero, marking a state's last cycle.
module spi_master_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator for the 16-bit {data,address} frame; one frame per accepted start.
// Build option: SPI_MASTER_LOOPBACK_EN samples the outgoing mosi instead of the synchronised miso.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int HALF_PERIOD = 8,
    parameter int SS_SETUP    = 8,
    parameter int SS_HOLD     = 8,
    parameter int SS_GAP      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [SPI_DATA_W-1:0] tx_data_i,
    input  logic [SPI_ADDR_W-1:0] tx_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [SPI_DATA_W-1:0] rx_data_o,
    output logic [SPI_ADDR_W-1:0] rx_addr_o,
    output logic                  ss_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    localparam int TIMER_W = $clog2(spi_max4(HALF_PERIOD, SS_SETUP, SS_HOLD, SS_GAP)) + 1;

    // Each state lasts N cycles, so the timer is loaded with N-1 on entry.
    localparam logic [TIMER_W-1:0] LD_HALF  = TIMER_W'(HALF_PERIOD - 1);
    localparam logic [TIMER_W-1:0] LD_SETUP = TIMER_W'(SS_SETUP - 1);
    localparam logic [TIMER_W-1:0] LD_HOLD  = TIMER_W'(SS_HOLD - 1);
    localparam logic [TIMER_W-1:0] LD_GAP   = TIMER_W'(SS_GAP - 1);

    spi_state_e             state_q, state_d;
    logic [SPI_FRAME_W-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_FRAME_W-1:0] rx_shift_q, rx_shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   ss_q, ss_d;
    logic                   sclk_q, sclk_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SPI_DATA_W-1:0]  rx_data_q, rx_data_d;
    logic [SPI_ADDR_W-1:0]  rx_addr_q, rx_addr_d;
    logic                   tmr_load_s;
    logic [TIMER_W-1:0]     tmr_val_s;
    logic                   tmr_tc_s;
    logic                   sample_s;

    spi_master_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .tc_o       (tmr_tc_s)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    // The MSB of the tx shift register is the registered mosi pin.
    assign sample_s = tx_shift_q[SPI_FRAME_W-1];
`else
    logic miso_meta_q;
    logic miso_sync_q;

    // Two-flop synchroniser for the asynchronous miso input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= miso_i;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign sample_s = miso_sync_q;
`endif

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        rx_addr_d  = rx_addr_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = LD_HALF;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tx_shift_d = {tx_data_i, tx_addr_i};
                    bit_cnt_d  = 4'd0;
                    ss_d       = 1'b0;
                    busy_d     = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_SETUP;
                    state_d    = ST_SETUP;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tmr_tc_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_HALF;
                    state_d    = ST_LOW;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_LOW: begin
                if (tmr_tc_s) begin
                    rx_shift_d = {rx_shift_q[SPI_FRAME_W-2:0], sample_s};
                    sclk_d     = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_HALF;
                    state_d    = ST_HIGH;
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (tmr_tc_s) begin
                    sclk_d     = 1'b0;
                    tmr_load_s = 1'b1;
                    if (bit_cnt_q == 4'd15) begin
                        tmr_val_s = LD_HOLD;
                        state_d   = ST_HOLD;
                    end else begin
                        // Shifting moves the next bit onto mosi as sclk falls.
                        tx_shift_d = {tx_shift_q[SPI_FRAME_W-2:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        tmr_val_s  = LD_HALF;
                        state_d    = ST_LOW;
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_HOLD: begin
                if (tmr_tc_s) begin
                    ss_d       = 1'b1;
                    done_d     = 1'b1;
                    rx_data_d  = rx_shift_q[SPI_FRAME_W-1:SPI_ADDR_W];
                    rx_addr_d  = rx_shift_q[SPI_ADDR_W-1:0];
                    bit_cnt_d  = 4'd0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_GAP;
                    state_d    = ST_GAP;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (tmr_tc_s) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ss_d    = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_shift_q <= {SPI_FRAME_W{1'b0}};
            rx_shift_q <= {SPI_FRAME_W{1'b0}};
            bit_cnt_q  <= 4'd0;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= {SPI_DATA_W{1'b0}};
            rx_addr_q  <= {SPI_ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_addr_q  <= rx_addr_d;
        end
    end

    assign ss_o      = ss_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = tx_shift_q[SPI_FRAME_W-1];
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign rx_addr_o = rx_addr_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural mode-0 slave returning a programmable frame.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int HP    = 4;
    localparam int SETUP = 8;
    localparam int HOLD  = 8;
    localparam int GAP   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic [7:0] tx_addr_i = 8'h00;
    logic       busy_o, done_o, ss_o, sclk_o, mosi_o, miso_i;
    logic [7:0] rx_data_o, rx_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    spi_master #(
        .HALF_PERIOD (HP),
        .SS_SETUP    (SETUP),
        .SS_HOLD     (HOLD),
        .SS_GAP      (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .tx_data_i (tx_data_i),
        .tx_addr_i (tx_addr_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rx_data_o (rx_data_o),
        .rx_addr_o (rx_addr_o),
        .ss_o      (ss_o),
        .sclk_o    (sclk_o),
        .mosi_o    (mosi_o),
        .miso_i    (miso_i)
    );

    always #5 clk = ~clk;

    // Slave model and bus monitor, sampled on the falling clk edge.
    logic [15:0] ret_frame = 16'h0000;
    logic [15:0] slv_sh = 16'h0000;
    logic [15:0] mosi_cap = 16'h0000;
    logic        sclk_prev = 1'b0;
    logic        ss_prev = 1'b1;
    int ss_low_run = 0, ss_high_run = 0, last_low = 0, last_gap = 0;
    int first_rise = 0, rises_in_frame = 0, last_rises = 0, rise_total = 0, done_total = 0;

    assign miso_i = slv_sh[15];

    always @(negedge clk) begin
        sclk_prev <= sclk_o;
        ss_prev   <= ss_o;
        if (done_o) done_total <= done_total + 1;
        if (!ss_o) begin
            ss_low_run  <= ss_low_run + 1;
            ss_high_run <= 0;
            if (ss_prev) begin
                last_gap       <= ss_high_run;
                slv_sh         <= ret_frame;
                rises_in_frame <= 0;
            end else if (sclk_prev && !sclk_o) begin
                slv_sh <= {slv_sh[14:0], 1'b0};
            end else if (sclk_o && !sclk_prev) begin
                rise_total     <= rise_total + 1;
                rises_in_frame <= rises_in_frame + 1;
                mosi_cap       <= {mosi_cap[14:0], mosi_o};
                if (rises_in_frame == 0) first_rise <= ss_low_run;
            end
        end else begin
            ss_high_run <= ss_high_run + 1;
            ss_low_run  <= 0;
            if (!ss_prev) begin
                last_low   <= ss_low_run;
                last_rises <= rises_in_frame;
            end
        end
    end

    function automatic logic [15:0] exp_rx(input logic [15:0] tx, input logic [15:0] ret);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx;
`else
        return ret;
`endif
    endfunction

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        @(negedge clk);
        tx_data_i = d;
        tx_addr_i = a;
        start_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ss_o !== 1'b1) begin n_errors++; $display("FAIL reset_ss: got %b expected 1", ss_o); end
        n_checks++; if (sclk_o !== 1'b0) begin n_errors++; $display("FAIL reset_sclk: got %b expected 0", sclk_o); end
        n_checks++; if (mosi_o !== 1'b0) begin n_errors++; $display("FAIL reset_mosi: got %b expected 0", mosi_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        n_checks++; if ({rx_data_o, rx_addr_o} !== 16'h0000) begin n_errors++; $display("FAIL reset_rx: got %h expected 0000", {rx_data_o, rx_addr_o}); end
        start_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        ret_frame = 16'h5AC3;
        d0 = done_total;
        send(8'hA5, 8'h3C);
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b expected 1", busy_o); end
        wait_done(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_timeout: got no done expected done"); end
        n_checks++; if ({rx_data_o, rx_addr_o} !== exp_rx(16'hA53C, 16'h5AC3)) begin n_errors++; $display("FAIL basic_rx: got %h expected %h", {rx_data_o, rx_addr_o}, exp_rx(16'hA53C, 16'h5AC3)); end
        @(negedge clk);
        n_checks++; if (done_o !== 1'b0) begin n_errors++; $display("FAIL basic_done_width: got %b expected 0", done_o); end
        n_checks++; if (mosi_cap !== 16'hA53C) begin n_errors++; $display("FAIL basic_mosi: got %h expected a53c", mosi_cap); end
        n_checks++; if (done_total - d0 != 1) begin n_errors++; $display("FAIL basic_done_count: got %0d expected 1", done_total - d0); end
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic test_timing();
        bit ok;
        ret_frame = 16'h00FF;
        send(8'h81, 8'h7E);
        wait_done(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL timing_timeout: got no done expected done"); end
        @(negedge clk);
        n_checks++; if (last_low != SETUP + 32 * HP + HOLD) begin n_errors++; $display("FAIL timing_ss_low: got %0d expected 144", last_low); end
        n_checks++; if (first_rise != SETUP + HP) begin n_errors++; $display("FAIL timing_first_rise: got %0d expected 12", first_rise); end
        n_checks++; if (last_rises != 16) begin n_errors++; $display("FAIL timing_rises: got %0d expected 16", last_rises); end
        n_checks++; if ({rx_data_o, rx_addr_o} !== exp_rx(16'h817E, 16'h00FF)) begin n_errors++; $display("FAIL timing_rx: got %h expected %h", {rx_data_o, rx_addr_o}, exp_rx(16'h817E, 16'h00FF)); end
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic test_ignore_start();
        bit ok;
        int d0;
        ret_frame = 16'h1234;
        d0 = done_total;
        send(8'h96, 8'h69);
        for (int c = 1; c <= 60; c++) begin
            start_i = (c == 3 || c == 20 || c == 60);
            if (start_i) begin
                tx_data_i = 8'hFF;
                tx_addr_i = 8'h00;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        wait_done(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ignore_timeout: got no done expected done"); end
        n_checks++; if ({rx_data_o, rx_addr_o} !== exp_rx(16'h9669, 16'h1234)) begin n_errors++; $display("FAIL ignore_rx: got %h expected %h", {rx_data_o, rx_addr_o}, exp_rx(16'h9669, 16'h1234)); end
        n_checks++; if (mosi_cap !== 16'h9669) begin n_errors++; $display("FAIL ignore_mosi: got %h expected 9669", mosi_cap); end
        repeat (GAP + 20) @(negedge clk);
        n_checks++; if (done_total - d0 != 1) begin n_errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_total - d0); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL ignore_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        ret_frame = 16'h0F0F;
        d0 = done_total;
        @(negedge clk);
        tx_data_i = 8'h11;
        tx_addr_i = 8'h22;
        start_i   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b_timeout: frame %0d got no done expected done", k); end
            n_checks++; if ({rx_data_o, rx_addr_o} !== exp_rx(16'h1122, 16'h0F0F)) begin n_errors++; $display("FAIL b2b_rx: frame %0d got %h expected %h", k, {rx_data_o, rx_addr_o}, exp_rx(16'h1122, 16'h0F0F)); end
            if (k < 2) begin
                @(negedge clk);
                for (int i = 0; i < 100 && ss_o; i++) @(negedge clk);
                @(negedge clk);
                n_checks++; if (last_gap != GAP + 1) begin n_errors++; $display("FAIL b2b_gap: frame %0d got %0d expected %0d", k, last_gap, GAP + 1); end
            end else begin
                start_i = 1'b0;
            end
        end
        repeat (GAP + 10) @(negedge clk);
        n_checks++; if (done_total - d0 != 3) begin n_errors++; $display("FAIL b2b_done_count: got %0d expected 3", done_total - d0); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL b2b_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0;
        ret_frame = 16'hBEEF;
        r0 = rise_total;
        send(8'h3C, 8'hA5);
        for (int i = 0; i < 500 && (rise_total - r0) < 7; i++) @(negedge clk);
        n_checks++; if (rise_total - r0 != 7) begin n_errors++; $display("FAIL midrst_rises: got %0d expected 7", rise_total - r0); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (ss_o !== 1'b1) begin n_errors++; $display("FAIL midrst_ss: got %b expected 1", ss_o); end
        n_checks++; if (sclk_o !== 1'b0) begin n_errors++; $display("FAIL midrst_sclk: got %b expected 0", sclk_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(8'h5A, 8'hC3);
        wait_done(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL midrst_timeout: got no done expected done"); end
        n_checks++; if ({rx_data_o, rx_addr_o} !== exp_rx(16'h5AC3, 16'hBEEF)) begin n_errors++; $display("FAIL midrst_rx: got %h expected %h", {rx_data_o, rx_addr_o}, exp_rx(16'h5AC3, 16'hBEEF)); end
        @(negedge clk);
        n_checks++; if (mosi_cap !== 16'h5AC3) begin n_errors++; $display("FAIL midrst_mosi: got %h expected 5ac3", mosi_cap); end
        n_checks++; if (last_rises != 16) begin n_errors++; $display("FAIL midrst_frame_rises: got %0d expected 16", last_rises); end
        repeat (GAP + 2) @(negedge clk);
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback();
        bit ok;
        ret_frame = 16'h0000;
        send(8'hFF, 8'h00);
        wait_done(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL loop_timeout: got no done expected done"); end
        n_checks++; if ({rx_data_o, rx_addr_o} !== 16'hFF00) begin n_errors++; $display("FAIL loop_rx: got %h expected ff00", {rx_data_o, rx_addr_o}); end
        repeat (GAP + 2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_timing();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
